// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   XLEN             : address/data width of the fetch path
//   DEFAULT_RESET_PC : default first fetch address after reset
//   INSTR_BYTES      : fetch PC stride (one 32-bit instruction)
//   fetch_entry_t    : prefetch FIFO payload {pc, instr}
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries between the memory response
// port and the decode handshake.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard all entries; wins over push/pop
//   full/empty : occupancy flags
//   count      : number of valid entries
//   head       : entry at the head (undefined content when empty)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still legal when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
    end

    // The fetch credit scheme must never let a push hit a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && full && !pop));
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word
// requests to a variable-latency instruction memory, buffers responses in
// a prefetch FIFO and hands {pc, instruction} to decode via valid/ready.
// A redirect flushes buffered entries and discards in-flight responses.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetched_count and
// discarded_count saturating counters.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   imem_req/addr/gnt            : request channel (addr held while !gnt)
//   imem_rvalid/rdata            : in-order response channel
//   redirect_valid/pc            : new fetch stream (low 2 bits ignored)
//   instr_valid/ready            : decode handshake
//   instruction_out, pc_out      : head entry, zero when empty
//   fetched_count, discarded_count (FETCH_PERF_CNT_EN only)
// XLEN must match fetch_pkg::XLEN (FIFO payload width).
module instr_fetch_unit #(
    parameter int              XLEN       = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instruction_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     fetched_count,
    output logic [31:0]     discarded_count
`else
    output logic [XLEN-1:0] pc_out
`endif
);
    import fetch_pkg::*;

    localparam int OW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_aligned;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   outstanding_nxt;
    logic [OW-1:0]   discard_cnt;
    logic [OW-1:0]   fifo_count;
    logic [OW:0]     in_use;
    logic            fetch_en;
    logic            grant;
    logic            drop_rsp;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign redirect_aligned = redirect_pc & ~XLEN'(INSTR_BYTES - 1);

    // Requests in flight plus buffered entries never exceed FIFO_DEPTH, so
    // every response always has a slot. fetch_en keeps the request line low
    // for one cycle after reset releases.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req  = fetch_en && !rst && (in_use < (OW+1)'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    // Responses belonging to a flushed stream, including one arriving in the
    // redirect cycle itself, are dropped.
    assign drop_rsp  = imem_rvalid && (redirect_valid || discard_cnt != '0);
    assign push      = imem_rvalid && !drop_rsp;
    assign pop       = instr_valid && instr_ready && !redirect_valid;
    assign push_data = '{pc: resp_pc, instr: imem_rdata};

    always_comb begin
        outstanding_nxt = outstanding;
        if (grant && !imem_rvalid)      outstanding_nxt = outstanding + OW'(1);
        else if (!grant && imem_rvalid) outstanding_nxt = outstanding - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_en    <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                fetch_pc    <= redirect_aligned;
                resp_pc     <= redirect_aligned;
                // Everything still in flight after this cycle is stale,
                // including a request granted right now.
                discard_cnt <= outstanding_nxt;
            end else begin
                if (grant) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
                if (push)  resp_pc  <= resp_pc + XLEN'(INSTR_BYTES);
                if (drop_rsp) discard_cnt <= discard_cnt - OW'(1);
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

    assign instr_valid     = !fifo_empty && !rst;
    assign instruction_out = instr_valid ? head.instr : '0;
    assign pc_out          = instr_valid ? head.pc    : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [OW:0]  disc_inc;
    logic [32:0]  disc_sum;

    assign disc_inc = {{OW{1'b0}}, drop_rsp}
                    + (redirect_valid ? {1'b0, fifo_count} : '0);
    assign disc_sum = {1'b0, discarded_count} + 33'(disc_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_count   <= '0;
            discarded_count <= '0;
        end else begin
            if (pop && fetched_count != '1) fetched_count <= fetched_count + 32'd1;
            discarded_count <= disc_sum[32] ? '1 : disc_sum[31:0];
        end
    end
`endif

    logic unused_full;
    assign unused_full = fifo_full;
endmodule
